// File: rtl/decoder_phase_sequencer.sv
// decoder_phase_sequencer
//   Sequences the instruction decoder tree. It owns:
//     - the timing-phase counter XPT,
//     - the opcode register ITABLE,
//     - the one-hot machine-cycle flags CM1/CMR/CMA,
//     - the multi-step continuation flags.
//   It consumes the decoder's PR_/P2_ command strobes and feeds XPT and ITABLE
//   back in true and complemented form.
//
// Parameters
//   XPT_LAST     last legal phase; XPT never advances past it
//   FETCH_PHASE  XPT value at which the opcode byte is captured during CM1
//
// Ports
//   clock, notReset        rising-edge clock, asynchronous active-low reset
//   mem_wait               bus wait; freezes the sequencer while high
//   data_in[7:0]           opcode byte from the data bus
//   PR_*/P2_* strobes      decoder commands, sampled only while decoder_enable=1
//   decoder_enable         enable to the top decoder (settle flag and ~mem_wait)
//   XPT/notXPT[3:0]        phase counter, true and complement
//   ITABLE/notITABLE[7:0]  opcode register, true and complement
//   CM1/CMR/CMA            machine-cycle flags, one-hot
//   I_LDlnnlHL_1, I_LDAlnnl_1, I_JPnn_1   continuation flags
//   seq_timeout            sticky: XPT stuck at XPT_LAST
module decoder_phase_sequencer #(
  parameter int XPT_LAST    = 15,
  parameter int FETCH_PHASE = 2
) (
  input  logic       clock,
  input  logic       notReset,
  input  logic       mem_wait,
  input  logic [7:0] data_in,
  input  logic       PR_Reset_XPT,
  input  logic       P2_Set_CM1,
  input  logic       P2_Reset_ITABLE,
  input  logic       P2_Set_CMR,
  input  logic       P2_Set_CMA,
  input  logic       P2_Set_ILDlnnlHL_1,
  input  logic       P2_Set_ILDAlnnl_1,
  input  logic       P2_Set_IJPnn_1,
  output logic       decoder_enable,
  output logic [3:0] XPT,
  output logic [3:0] notXPT,
  output logic [7:0] ITABLE,
  output logic [7:0] notITABLE,
  output logic       CM1,
  output logic       CMR,
  output logic       CMA,
  output logic       I_LDlnnlHL_1,
  output logic       I_LDAlnnl_1,
  output logic       I_JPnn_1,
  output logic       seq_timeout
);

  localparam logic [3:0] XPT_LAST_V    = 4'(XPT_LAST);
  localparam logic [3:0] FETCH_PHASE_V = 4'(FETCH_PHASE);

  typedef enum logic [2:0] {
    ST_M1 = 3'b001,
    ST_MR = 3'b010,
    ST_MA = 3'b100
  } cycle_e;

  cycle_e state;
  logic   settled;

  // The decoder is held off for one edge after reset so that its inputs
  // (XPT/ITABLE feedback) have settled before any strobe is acted on.
  assign decoder_enable = settled & ~mem_wait;

  // Complements are derived from the same registers, so they are exact
  // every cycle, including while reset is asserted.
  assign notXPT    = ~XPT;
  assign notITABLE = ~ITABLE;

  assign CM1 = (state == ST_M1);
  assign CMR = (state == ST_MR);
  assign CMA = (state == ST_MA);

  // Settle flag
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) settled <= 1'b0;
    else           settled <= 1'b1;
  end

  // Phase counter and timeout
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      XPT         <= 4'h0;
      seq_timeout <= 1'b0;
    end else if (decoder_enable) begin
      if (PR_Reset_XPT) begin
        XPT <= 4'h0;
      end else if (XPT < XPT_LAST_V) begin
        XPT <= XPT + 4'h1;
      end else begin
        seq_timeout <= 1'b1;
      end
    end
  end

  // Opcode register: clear beats capture
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      ITABLE <= 8'h00;
    end else if (decoder_enable) begin
      if (P2_Reset_ITABLE) begin
        ITABLE <= 8'h00;
      end else if (CM1 && (XPT == FETCH_PHASE_V)) begin
        ITABLE <= data_in;
      end
    end
  end

  // Machine-cycle FSM, priority M1 > MR > MA
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state <= ST_M1;
    end else if (decoder_enable) begin
      if (P2_Set_CM1)      state <= ST_M1;
      else if (P2_Set_CMR) state <= ST_MR;
      else if (P2_Set_CMA) state <= ST_MA;
    end
  end

  // Continuation flags: a set strobe beats the end-of-instruction clear
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      I_LDlnnlHL_1 <= 1'b0;
      I_LDAlnnl_1  <= 1'b0;
      I_JPnn_1     <= 1'b0;
    end else if (decoder_enable) begin
      if (P2_Set_ILDlnnlHL_1) I_LDlnnlHL_1 <= 1'b1;
      else if (P2_Set_CM1)    I_LDlnnlHL_1 <= 1'b0;
      if (P2_Set_ILDAlnnl_1)  I_LDAlnnl_1  <= 1'b1;
      else if (P2_Set_CM1)    I_LDAlnnl_1  <= 1'b0;
      if (P2_Set_IJPnn_1)     I_JPnn_1     <= 1'b1;
      else if (P2_Set_CM1)    I_JPnn_1     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_phase_sequencer.sv
module tb_decoder_phase_sequencer;

  logic       clock = 1'b0;
  logic       notReset;
  logic       mem_wait;
  logic [7:0] data_in;
  logic       PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE, P2_Set_CMR, P2_Set_CMA;
  logic       P2_Set_ILDlnnlHL_1, P2_Set_ILDAlnnl_1, P2_Set_IJPnn_1;
  logic       decoder_enable;
  logic [3:0] XPT, notXPT;
  logic [7:0] ITABLE, notITABLE;
  logic       CM1, CMR, CMA, I_LDlnnlHL_1, I_LDAlnnl_1, I_JPnn_1, seq_timeout;

  int vectors = 0;
  int miscompares = 0;

  decoder_phase_sequencer #(.XPT_LAST(15), .FETCH_PHASE(2)) dut (
    .clock(clock), .notReset(notReset), .mem_wait(mem_wait), .data_in(data_in),
    .PR_Reset_XPT(PR_Reset_XPT), .P2_Set_CM1(P2_Set_CM1),
    .P2_Reset_ITABLE(P2_Reset_ITABLE), .P2_Set_CMR(P2_Set_CMR),
    .P2_Set_CMA(P2_Set_CMA), .P2_Set_ILDlnnlHL_1(P2_Set_ILDlnnlHL_1),
    .P2_Set_ILDAlnnl_1(P2_Set_ILDAlnnl_1), .P2_Set_IJPnn_1(P2_Set_IJPnn_1),
    .decoder_enable(decoder_enable), .XPT(XPT), .notXPT(notXPT),
    .ITABLE(ITABLE), .notITABLE(notITABLE), .CM1(CM1), .CMR(CMR), .CMA(CMA),
    .I_LDlnnlHL_1(I_LDlnnlHL_1), .I_LDAlnnl_1(I_LDAlnnl_1), .I_JPnn_1(I_JPnn_1),
    .seq_timeout(seq_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // One active edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_strobes();
    PR_Reset_XPT = 0; P2_Set_CM1 = 0; P2_Reset_ITABLE = 0; P2_Set_CMR = 0;
    P2_Set_CMA = 0; P2_Set_ILDlnnlHL_1 = 0; P2_Set_ILDAlnnl_1 = 0; P2_Set_IJPnn_1 = 0;
  endtask

  initial begin
    notReset = 1'b0;
    mem_wait = 1'b0;
    data_in  = 8'h3A;
    clear_strobes();
    step(); step();

    // Reset values
    check("rst_xpt", {4'h0, XPT}, 8'h00);
    check("rst_notxpt", {4'h0, notXPT}, 8'h0F);
    check("rst_itable", ITABLE, 8'h00);
    check("rst_notitable", notITABLE, 8'hFF);
    check("rst_cycle", {5'b0, CMA, CMR, CM1}, 8'h01);
    check("rst_flags", {5'b0, I_LDlnnlHL_1, I_LDAlnnl_1, I_JPnn_1}, 8'h00);
    check("rst_timeout", {7'b0, seq_timeout}, 8'h00);
    check("rst_enable", {7'b0, decoder_enable}, 8'h00);

    // Reset release: settle edge, then counting
    notReset = 1'b1;
    #1;
    check("settle_en_lo", {7'b0, decoder_enable}, 8'h00);
    step();
    check("settle_xpt0", {4'h0, XPT}, 8'h00);
    check("settle_en_hi", {7'b0, decoder_enable}, 8'h01);
    step();
    check("count_xpt1", {4'h0, XPT}, 8'h01);
    step();
    check("count_xpt2", {4'h0, XPT}, 8'h02);
    check("pre_fetch_itable", ITABLE, 8'h00);
    step();
    check("count_xpt3", {4'h0, XPT}, 8'h03);
    check("fetch_itable", ITABLE, 8'h3A);
    check("fetch_notitable", notITABLE, 8'hC5);
    check("fetch_cm1", {7'b0, CM1}, 8'h01);

    // PR_Reset_XPT at XPT=5
    step(); step();
    check("count_xpt5", {4'h0, XPT}, 8'h05);
    PR_Reset_XPT = 1;
    step();
    PR_Reset_XPT = 0;
    check("prrst_xpt", {4'h0, XPT}, 8'h00);
    check("prrst_notxpt", {4'h0, notXPT}, 8'h0F);
    check("prrst_timeout", {7'b0, seq_timeout}, 8'h00);

    // 20 cycles without restart: sticks at 15, timeout sets
    for (int i = 0; i < 15; i++) step();
    check("stick_xpt15_first", {4'h0, XPT}, 8'h0F);
    check("stick_timeout_not_yet", {7'b0, seq_timeout}, 8'h00);
    for (int i = 0; i < 5; i++) step();
    check("stick_xpt15", {4'h0, XPT}, 8'h0F);
    check("stick_notxpt", {4'h0, notXPT}, 8'h00);
    check("stick_timeout", {7'b0, seq_timeout}, 8'h01);
    PR_Reset_XPT = 1;
    step();
    PR_Reset_XPT = 0;
    check("timeout_sticky_xpt", {4'h0, XPT}, 8'h00);
    check("timeout_sticky", {7'b0, seq_timeout}, 8'h01);

    // notReset pulse clears timeout
    #2 notReset = 1'b0;
    #1;
    check("pulse_timeout", {7'b0, seq_timeout}, 8'h00);
    check("pulse_itable", ITABLE, 8'h00);
    notReset = 1'b1;
    step();
    check("pulse_settle_xpt", {4'h0, XPT}, 8'h00);

    // Cycle FSM priority
    P2_Set_CMR = 1; P2_Set_CMA = 1;
    step();
    clear_strobes();
    check("cmr_cma_cycle", {5'b0, CMA, CMR, CM1}, 8'h02);
    P2_Set_CM1 = 1;
    step();
    clear_strobes();
    check("cm1_cycle", {5'b0, CMA, CMR, CM1}, 8'h01);
    check("xpt_at_2", {4'h0, XPT}, 8'h02);
    P2_Set_CMA = 1;
    step();
    clear_strobes();
    check("cma_cycle", {5'b0, CMA, CMR, CM1}, 8'h04);
    check("capture_at_cm1_edge", ITABLE, 8'h3A);

    // Continuation flags
    P2_Set_ILDAlnnl_1 = 1;
    step();
    clear_strobes();
    check("flag_ldanl", {5'b0, I_LDlnnlHL_1, I_LDAlnnl_1, I_JPnn_1}, 8'h02);
    P2_Set_IJPnn_1 = 1; P2_Set_CM1 = 1;
    step();
    clear_strobes();
    check("flag_jp_wins", {5'b0, I_LDlnnlHL_1, I_LDAlnnl_1, I_JPnn_1}, 8'h01);
    check("flag_jp_cycle", {5'b0, CMA, CMR, CM1}, 8'h01);
    check("xpt_at_5", {4'h0, XPT}, 8'h05);

    // ITABLE clear
    P2_Reset_ITABLE = 1;
    step();
    clear_strobes();
    check("itable_clear", ITABLE, 8'h00);
    check("itable_clear_not", notITABLE, 8'hFF);

    // Clear beats capture at the fetch phase
    PR_Reset_XPT = 1;
    step();
    clear_strobes();
    step(); step();
    check("xpt2_again", {4'h0, XPT}, 8'h02);
    data_in = 8'h5A;
    P2_Reset_ITABLE = 1;
    step();
    clear_strobes();
    check("clear_beats_capture", ITABLE, 8'h00);

    // mem_wait at XPT=2
    PR_Reset_XPT = 1;
    step();
    clear_strobes();
    step(); step();
    check("xpt2_wait", {4'h0, XPT}, 8'h02);
    data_in  = 8'hC3;
    mem_wait = 1'b1;
    P2_Set_CMA = 1;
    #1;
    check("wait_enable", {7'b0, decoder_enable}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_xpt_hold", {4'h0, XPT}, 8'h02);
      check("wait_no_capture", ITABLE, 8'h00);
    end
    check("wait_strobe_ignored", {5'b0, CMA, CMR, CM1}, 8'h01);
    clear_strobes();
    mem_wait = 1'b0;
    step();
    check("post_wait_capture", ITABLE, 8'hC3);
    check("post_wait_xpt", {4'h0, XPT}, 8'h03);

    // Reset asserted in the middle of a wait
    mem_wait = 1'b1;
    step();
    #2 notReset = 1'b0;
    #1;
    check("midwait_rst_xpt", {4'h0, XPT}, 8'h00);
    check("midwait_rst_itable", ITABLE, 8'h00);
    check("midwait_rst_notitable", notITABLE, 8'hFF);
    check("midwait_rst_flags", {5'b0, I_LDlnnlHL_1, I_LDAlnnl_1, I_JPnn_1}, 8'h00);
    check("midwait_rst_cycle", {5'b0, CMA, CMR, CM1}, 8'h01);
    check("midwait_rst_enable", {7'b0, decoder_enable}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
